color_cmd_driver: RTL and testbench
===================================

COLOR_CMD_DRIVER -- requirements
Module: color_cmd_driver

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8: cycles to wait in WAIT for the target code, legal range 2..255.
REQ-002 The block SHALL have parameter MAX_RETRY, default 2: extra toggle attempts after the first, legal range 0..7.
REQ-003 clk  input  1  sole clock; all flops rise on posedge clk.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_color  input  1  target colour: 0 Blue, 1 Red.
REQ-007 req_ready  output  1  request accepted when req_valid and req_ready are both high on a clk edge.
REQ-008 cmd  output  2  command to the colour FSM: 2'h1 toggle, 2'h0 hold.
REQ-009 code  input  2  colour FSM output code: 2'h1 Blue, 2'h2 Red, 2'h0/2'h3 invalid.
REQ-010 done_valid  output  1  one-cycle completion pulse.
REQ-011 done_err  output  1  qualifies done_valid: 1 failure, 0 success.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 toggle_cnt  output  8  count of toggle pulses issued, saturating at 8'hFF.

Function
REQ-014 The FSM SHALL have states IDLE, CHECK, PULSE, WAIT, DONE.
REQ-015 IDLE: req_ready=1; on accept latch req_color into target, clear retry count to 0, go to CHECK; otherwise stay.
REQ-016 req_ready SHALL be 0 in all non-IDLE states; req_valid outside IDLE SHALL be ignored.
REQ-017 CHECK (1 cycle): if code matches target, go to DONE with err=0 (no toggle issued).
REQ-018 CHECK: if code is invalid (2'h0 or 2'h3), go to DONE with err=1.
REQ-019 CHECK: in all other cases, go to PULSE.
REQ-020 PULSE (1 cycle): cmd=2'h1; toggle_cnt += 1 unless it is 8'hFF; clear the timer to 0; go to WAIT.
REQ-021 In every state except PULSE, cmd SHALL be 2'h0; cmd SHALL be registered, never combinational from code.
REQ-022 WAIT: the timer increments each cycle.
REQ-023 WAIT: if code matches target, go to DONE with err=0; the match check has priority over timeout in the same cycle.
REQ-024 WAIT: when the timer equals TIMEOUT-1 without a match, and retry < MAX_RETRY, increment retry and go to CHECK.
REQ-025 WAIT: when the timer equals TIMEOUT-1 without a match, and retry == MAX_RETRY, go to DONE with err=1.
REQ-026 DONE: done_valid=1 and done_err=latched err for exactly one cycle, then go to IDLE.
REQ-027 done_err SHALL be 0 whenever done_valid is 0.
REQ-028 Latency for an already-matching target SHALL be 2 cycles from accept to done_valid (CHECK, DONE).
REQ-029 Latency for a single successful toggle SHALL be 4 cycles from accept to done_valid (CHECK, PULSE, WAIT, DONE), given the FSM updates code on the edge after cmd=2'h1.
REQ-030 A code change in WAIT to the non-target valid colour SHALL NOT abort the request; it is treated as no match.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, cmd=2'h0, done_valid=0, done_err=0, toggle_cnt=0, timer=0, retry=0, target=0.
REQ-032 While in reset, req_ready SHALL be 1 (IDLE) and busy SHALL be 0.
REQ-033 Reset asserted mid-request SHALL drop the request with no done_valid pulse; cmd SHALL return to 2'h0 immediately.
REQ-034 Reset deassertion SHALL take effect on the next clk edge.

Structure
REQ-035 Shared package color_pkg SHALL hold: Color_state enum (Blue=1'h0, Red=1'h1), CODE_BLUE=2'h1, CODE_RED=2'h2, CMD_HOLD=2'h0, CMD_TOGGLE=2'h1, and the driver state enum.
REQ-036 Sub-module color_cmd_timer (clear, enable, expire at TIMEOUT-1) SHALL implement the WAIT timer; all other logic SHALL be in color_cmd_driver.

Verification
REQ-037 Reset, code=2'h2, request Red -> done_valid at accept+2, done_err=0, cmd never 2'h1, toggle_cnt=0.
REQ-038 Bench model of the colour FSM at Red, request Blue -> cmd=2'h1 for exactly 1 cycle, code=2'h1, done_valid at accept+4, done_err=0, toggle_cnt=1.
REQ-039 code stuck at 2'h2, request Blue, defaults -> 3 toggle pulses spaced TIMEOUT+2 cycles apart, then done_err=1, toggle_cnt=3.
REQ-040 code=2'h3, any request -> done_valid at accept+2 with done_err=1, no toggle pulse.
REQ-041 rst_n low during WAIT -> cmd=2'h0 and busy=0 without waiting for an edge, no done_valid; a new request afterwards completes normally.
REQ-042 Back-to-back requests with req_valid held high -> second accept on the cycle after DONE; toggle_cnt saturates at 8'hFF after 300 toggles.

Source files
------------

// File: rtl/color_pkg.sv
// Shared types and constants for the colour command driver and its timer.
package color_pkg;

    typedef enum logic {
        Blue = 1'b0,
        Red  = 1'b1
    } Color_state;

    localparam logic [1:0] CODE_BLUE  = 2'h1;
    localparam logic [1:0] CODE_RED   = 2'h2;
    localparam logic [1:0] CMD_HOLD   = 2'h0;
    localparam logic [1:0] CMD_TOGGLE = 2'h1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } drv_state_e;

    // Code the colour FSM reports when it sits at the given colour.
    function automatic logic [1:0] color_code(input Color_state c);
        return (c == Red) ? CODE_RED : CODE_BLUE;
    endfunction

    // Only the two colour codes are meaningful; 2'h0 and 2'h3 are faults.
    function automatic logic code_is_valid(input logic [1:0] c);
        return (c == CODE_BLUE) || (c == CODE_RED);
    endfunction

endpackage

// File: rtl/color_cmd_timer.sv
// WAIT-state timer: cleared in PULSE, counts up while enabled, flags the
// last cycle of the wait window (count == TIMEOUT-1).
module color_cmd_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear wins over enable so a fresh window always starts at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LAST);

endmodule

// File: rtl/color_cmd_driver.sv
// Drives toggle commands into an external two-colour FSM until its reported
// code matches the requested colour, with bounded wait and retry.
//
//   state | meaning
//   IDLE  | ready for a request
//   CHECK | compare code with target, decide done / fault / toggle
//   PULSE | one-cycle toggle command, count it, restart the timer
//   WAIT  | wait for the code to reach target, retry on timeout
//   DONE  | one-cycle completion pulse with error flag
module color_cmd_driver
    import color_pkg::*;
#(
    parameter int TIMEOUT   = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_color,
    output logic       req_ready,
    output logic [1:0] cmd,
    input  logic [1:0] code,
    output logic       done_valid,
    output logic       done_err,
    output logic       busy,
    output logic [7:0] toggle_cnt
);

    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    drv_state_e state_q, state_d;
    Color_state target_q, target_d;
    logic [2:0] retry_q, retry_d;
    logic [1:0] cmd_q, cmd_d;
    logic       done_valid_q, done_valid_d;
    logic       done_err_q, done_err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_d;
    logic       code_match;
    logic       timer_clear;
    logic       timer_en;
    logic       timer_expire;

    color_cmd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    assign code_match = (code == color_code(target_q));

    // Next-state logic; cmd and done are derived from the next state so they
    // come straight out of flops and line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        retry_d     = retry_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    target_d = Color_state'(req_color);
                    retry_d  = '0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (code_match) begin
                    state_d = ST_DONE;
                end else if (!code_is_valid(code)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                timer_clear = 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                if (code_match) begin
                    state_d = ST_DONE;
                end else if (timer_expire) begin
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 3'd1;
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cmd_d        = (state_d == ST_PULSE) ? CMD_TOGGLE : CMD_HOLD;
        done_valid_d = (state_d == ST_DONE);
        done_err_d   = err_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= Blue;
            retry_q      <= '0;
            cmd_q        <= CMD_HOLD;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            retry_q      <= retry_d;
            cmd_q        <= cmd_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign cmd        = cmd_q;
    assign done_valid = done_valid_q;
    assign done_err   = done_err_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_color_cmd_driver.sv
// Bench for color_cmd_driver: cycle model of the request rules, a model of
// the external colour FSM, directed scenarios and a randomized run.
module tb_color_cmd_driver;

    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_color = 1'b0;
    logic       req_ready;
    logic [1:0] cmd;
    logic [1:0] code;
    logic       done_valid;
    logic       done_err;
    logic       busy;
    logic [7:0] toggle_cnt;

    int total = 0;
    int bad   = 0;

    // code source: forced value, or a modelled colour FSM (0 Blue, 1 Red)
    bit         code_mode = 1'b1;
    logic [1:0] code_force = 2'h2;
    bit         fsm_col = 1'b0;
    bit         fsm_set = 1'b0;
    bit         fsm_set_val = 1'b0;

    assign code = code_mode ? code_force : (fsm_col ? 2'h2 : 2'h1);

    color_cmd_driver #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_color  (req_color),
        .req_ready  (req_ready),
        .cmd        (cmd),
        .code       (code),
        .done_valid (done_valid),
        .done_err   (done_err),
        .busy       (busy),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    // external colour FSM: flips on the edge after a toggle command
    always @(posedge clk) begin
        if (fsm_set) fsm_col <= fsm_set_val;
        else if (cmd == 2'h1) fsm_col <= ~fsm_col;
    end

    typedef struct {
        bit busy;
        bit check;
        bit pulse;
        bit done;
        bit err;
        bit target;
        int wait_left;
        int tries_left;
        int cnt;
    } model_t;

    model_t m;

    function automatic model_t step(model_t s, bit rv, bit rc, logic [1:0] cd);
        model_t n;
        bit hit;
        bit junk;
        n = s;
        hit = (cd == (s.target ? 2'h2 : 2'h1));
        junk = (cd == 2'h0) || (cd == 2'h3);
        if (s.done) begin
            n.done = 0; n.busy = 0; n.err = 0;
        end else if (!s.busy) begin
            if (rv) begin
                n.busy = 1; n.check = 1; n.target = rc; n.tries_left = MAX_RETRY;
            end
        end else if (s.check) begin
            n.check = 0;
            if (hit) n.done = 1;
            else if (junk) begin n.done = 1; n.err = 1; end
            else n.pulse = 1;
        end else if (s.pulse) begin
            n.pulse = 0;
            n.wait_left = TIMEOUT;
            if (s.cnt < 255) n.cnt = s.cnt + 1;
        end else begin
            if (hit) begin
                n.done = 1; n.wait_left = 0;
            end else if (s.wait_left == 1) begin
                n.wait_left = 0;
                if (s.tries_left > 0) begin
                    n.tries_left = s.tries_left - 1; n.check = 1;
                end else begin
                    n.done = 1; n.err = 1;
                end
            end else begin
                n.wait_left = s.wait_left - 1;
            end
        end
        return n;
    endfunction

    // reference model advances on the same edges as the design
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else m <= step(m, req_valid, req_color, code);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout expected=event at %0t", name, $time);
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("req_ready", int'(req_ready), m.busy ? 0 : 1);
        chk("busy", int'(busy), int'(m.busy));
        chk("cmd", int'(cmd), m.pulse ? 1 : 0);
        chk("done_valid", int'(done_valid), int'(m.done));
        chk("done_err", int'(done_err), (m.done && m.err) ? 1 : 0);
        chk("toggle_cnt", int'(toggle_cnt), m.cnt);
    end

    task automatic apply_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // lat counts negedges after the accept cycle; gap is pulse-to-pulse spacing
    task automatic run_req(input bit color, output int lat, output bit err,
                           output int pulses, output int gap);
        int guard;
        bit got;
        int first_p;
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_color = color;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) fail_now("accept_wait");
        @(posedge clk); #2 req_valid = 1'b0;
        lat = 0; err = 0; pulses = 0; gap = 0; got = 0; first_p = -1;
        for (int i = 1; i < 200 && !got; i++) begin
            @(negedge clk);
            lat = i;
            if (cmd == 2'h1) begin
                pulses++;
                if (first_p < 0) first_p = i;
                else if (gap == 0) gap = i - first_p;
            end
            if (done_valid) begin
                got = 1;
                err = done_err;
            end
        end
        if (!got) fail_now("done_wait");
    endtask

    task automatic reset_mid(input int extra, input string tag);
        int guard;
        int dv;
        int lat, pulses, gap;
        bit err;
        code_mode = 1'b1;
        code_force = 2'h2;
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_color = 1'b0;
        @(negedge clk);
        @(posedge clk); #2 req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cmd != 2'h1 && guard < 20);
        if (cmd != 2'h1) fail_now({tag, "_pulse_wait"});
        repeat (extra) @(negedge clk);
        #1;
        chk({tag, "_busy_before"}, int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk({tag, "_cmd_in_reset"}, int'(cmd), 0);
        chk({tag, "_busy_in_reset"}, int'(busy), 0);
        chk({tag, "_ready_in_reset"}, int'(req_ready), 1);
        dv = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_valid) dv++;
        end
        chk({tag, "_no_done"}, dv, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        run_req(1'b1, lat, err, pulses, gap);
        chk({tag, "_after_lat"}, lat, 2);
        chk({tag, "_after_err"}, int'(err), 0);
    endtask

    initial begin
        int lat, pulses, gap, ndone, guard;
        bit err, prev_done, gap_seen;

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_done", int'(done_valid), 0);
        chk("rst_cnt", int'(toggle_cnt), 0);

        // already at target
        code_mode = 1'b1; code_force = 2'h2;
        run_req(1'b1, lat, err, pulses, gap);
        chk("match_lat", lat, 2);
        chk("match_err", int'(err), 0);
        chk("match_pulses", pulses, 0);
        chk("match_cnt", int'(toggle_cnt), 0);

        // single toggle through the colour FSM model
        @(posedge clk); #2 fsm_set = 1'b1; fsm_set_val = 1'b1;
        @(posedge clk); #2 fsm_set = 1'b0; code_mode = 1'b0;
        run_req(1'b0, lat, err, pulses, gap);
        chk("toggle_lat", lat, 4);
        chk("toggle_err", int'(err), 0);
        chk("toggle_pulses", pulses, 1);
        chk("toggle_code", int'(code), 1);
        chk("toggle_cnt", int'(toggle_cnt), 1);

        // stuck code: all retries exhausted
        apply_reset();
        code_mode = 1'b1; code_force = 2'h2;
        run_req(1'b0, lat, err, pulses, gap);
        chk("stuck_pulses", pulses, MAX_RETRY + 1);
        chk("stuck_gap", gap, TIMEOUT + 2);
        chk("stuck_lat", lat, (MAX_RETRY + 1) * (TIMEOUT + 2) + 1);
        chk("stuck_err", int'(err), 1);
        chk("stuck_cnt", int'(toggle_cnt), 3);

        // invalid codes
        code_force = 2'h3;
        run_req(1'b1, lat, err, pulses, gap);
        chk("inv3_lat", lat, 2);
        chk("inv3_err", int'(err), 1);
        chk("inv3_pulses", pulses, 0);
        code_force = 2'h0;
        run_req(1'b0, lat, err, pulses, gap);
        chk("inv0_lat", lat, 2);
        chk("inv0_err", int'(err), 1);

        // reset in the middle of a request
        reset_mid(2, "rst_wait");
        reset_mid(0, "rst_pulse");

        // back-to-back requests, alternating colours, until saturation
        apply_reset();
        code_mode = 1'b0;
        @(posedge clk); #2;
        req_color = ~fsm_col;
        req_valid = 1'b1;
        ndone = 0; prev_done = 0; gap_seen = 0; guard = 0;
        while (ndone < 300 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (prev_done && !gap_seen) begin
                chk("b2b_ready_after_done", int'(req_ready), 1);
                gap_seen = 1;
            end
            prev_done = done_valid;
            if (done_valid) begin
                ndone++;
                req_color = ~req_color;
            end
        end
        if (ndone < 300) fail_now("b2b_done_count");
        @(posedge clk); #2 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_sat_cnt", int'(toggle_cnt), 255);

        // randomized traffic
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            req_valid = ($urandom_range(0, 3) != 0);
            req_color = 1'($urandom);
            if ($urandom_range(0, 15) == 0) code_mode = 1'($urandom);
            if ($urandom_range(0, 3) == 0) code_force = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk); #2 rst_n = 1'b1; req_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
